// File: rtl/sap1_sequencer.sv
// sap1_sequencer: SAP-1 T-state counter and microcode decoder with run/halted/program control.
// All controls are forced low while rst is asserted and outside RUN (halt excepted in HALTED).
module sap1_sequencer #(
    parameter int FLAG_C_BIT = 0,
    parameter int FLAG_Z_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [3:0] flags,
    input  logic       pr_mode,
    output logic       halt,
    output logic       reg_a_in,
    output logic       reg_a_out,
    output logic       reg_b_in,
    output logic       reg_b_out,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       instr_in,
    output logic       instr_out,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       reg_out,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_jmp,
    output logic [3:0] reg_flags_in,
    output logic [3:0] step_out
);
    typedef enum logic [1:0] {RUN, HALTED, PROGRAM} state_t;

    state_t     state, state_nx;
    logic [2:0] step, step_nx, last;
    logic       armed;
    logic       is_lda, is_add, is_sub, is_sta, is_ldi, is_jmp, is_jc, is_jz, is_out, is_hlt;
    logic       s0, s1, s2, s3, s4, run, unused_flags;

    assign is_lda = opcode == 4'h1;
    assign is_add = opcode == 4'h2;
    assign is_sub = opcode == 4'h3;
    assign is_sta = opcode == 4'h4;
    assign is_ldi = opcode == 4'h5;
    assign is_jmp = opcode == 4'h6;
    assign is_jc  = opcode == 4'h7;
    assign is_jz  = opcode == 4'h8;
    assign is_out = opcode == 4'hE;
    assign is_hlt = opcode == 4'hF;
    assign last   = (is_lda || is_sta) ? 3'd3 : (is_add || is_sub) ? 3'd4 : 3'd2;
    assign unused_flags = ^flags;

    // The first edge after reset release only arms the sequencer, so T0 spans it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            step  <= 3'd0;
            armed <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            state <= state_nx;
            step  <= step_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        case (state)
            RUN: begin
                state_nx = (step != last) ? RUN : pr_mode ? PROGRAM : is_hlt ? HALTED : RUN;
                step_nx  = (step != last) ? step + 3'd1 : (is_hlt && !pr_mode) ? step : 3'd0;
            end
            HALTED: begin
                state_nx = pr_mode ? PROGRAM : HALTED;
                step_nx  = pr_mode ? 3'd0 : step;
            end
            PROGRAM: begin
                state_nx = pr_mode ? PROGRAM : RUN;
                step_nx  = 3'd0;
            end
            default: begin
                state_nx = RUN;
                step_nx  = 3'd0;
            end
        endcase
    end

    assign run = rst && state == RUN;
    assign s0  = run && step == 3'd0;
    assign s1  = run && step == 3'd1;
    assign s2  = run && step == 3'd2;
    assign s3  = run && step == 3'd3;
    assign s4  = run && step == 3'd4;

    always_comb begin
        halt         = rst && (state == HALTED || (s2 && is_hlt));
        pc_out       = s0;
        mar_in       = s0 || (s2 && (is_lda || is_add || is_sub || is_sta));
        ram_out      = s1 || (s3 && (is_lda || is_add || is_sub));
        instr_in     = s1;
        pc_inc       = s1;
        instr_out    = s2 && (is_lda || is_add || is_sub || is_sta || is_ldi || is_jmp || is_jc || is_jz);
        reg_a_in     = (s2 && is_ldi) || (s3 && is_lda) || (s4 && (is_add || is_sub));
        reg_b_in     = s3 && (is_add || is_sub);
        reg_b_out    = 1'b0;
        alu_out      = s4 && (is_add || is_sub);
        alu_sub      = s4 && is_sub;
        reg_flags_in = {4{s4 && (is_add || is_sub)}};
        reg_a_out    = (s3 && is_sta) || (s2 && is_out);
        ram_in       = s3 && is_sta;
        reg_out      = s2 && is_out;
        pc_jmp       = s2 && (is_jmp || (is_jc && flags[FLAG_C_BIT]) || (is_jz && flags[FLAG_Z_BIT]));
        step_out     = {1'b0, step};
    end
endmodule

// File: tb/tb_sap1_sequencer.sv
// tb_sap1_sequencer: directed-vector check of fetch/execute decode, halt, program mode and reset.
module tb_sap1_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] opcode = 4'h1;
    logic [3:0] flags = 4'h0;
    logic       pr_mode = 1'b0;
    logic       halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub;
    logic       instr_in, instr_out, mar_in, ram_in, ram_out, reg_out, pc_inc, pc_out, pc_jmp;
    logic [3:0] reg_flags_in, step_out;
    int         n_cmp = 0;
    int         n_err = 0;

    sap1_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flags(flags), .pr_mode(pr_mode),
        .halt(halt), .reg_a_in(reg_a_in), .reg_a_out(reg_a_out), .reg_b_in(reg_b_in),
        .reg_b_out(reg_b_out), .alu_out(alu_out), .alu_sub(alu_sub), .instr_in(instr_in),
        .instr_out(instr_out), .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
        .reg_out(reg_out), .pc_inc(pc_inc), .pc_out(pc_out), .pc_jmp(pc_jmp),
        .reg_flags_in(reg_flags_in), .step_out(step_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs every 1-bit control except halt, so "all others zero" is one comparison.
    function automatic logic [15:0] ctl();
        return {reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub, instr_in,
                instr_out, mar_in, ram_in, ram_out, reg_out, pc_inc, pc_out, pc_jmp, 1'b0};
    endfunction

    initial begin
        tick(); tick();
        check("rst_step", step_out, 0);
        check("rst_ctl", ctl(), 0);
        check("rst_halt", halt, 0);
        rst = 1'b1;
        #1;
        check("t0_pc_out", pc_out, 1);
        check("t0_mar_in", mar_in, 1);
        tick();
        check("arm_step", step_out, 0);
        tick();
        check("lda_t1_step", step_out, 1);
        check("lda_t1", {ram_out, instr_in, pc_inc}, 3'b111);
        tick();
        check("lda_t2", {instr_out, mar_in, step_out}, {2'b11, 4'd2});
        tick();
        check("lda_t3", {ram_out, reg_a_in, step_out}, {2'b11, 4'd3});
        check("lda_t3_flags", reg_flags_in, 0);
        tick();
        check("lda_wrap", step_out, 0);
        opcode = 4'h3;
        tick(); tick();
        check("sub_t2_mar", mar_in, 1);
        tick();
        check("sub_t3", {ram_out, reg_b_in}, 2'b11);
        tick();
        check("sub_t4", {alu_out, alu_sub, reg_a_in, step_out}, {3'b111, 4'd4});
        check("sub_t4_flags", reg_flags_in, 4'hF);
        tick();
        check("sub_wrap", step_out, 0);
        opcode = 4'h7;
        flags = 4'b0001;
        tick(); tick();
        check("jc_taken", {instr_out, pc_jmp}, 2'b11);
        tick();
        check("jc_wrap", step_out, 0);
        flags = 4'b0000;
        tick(); tick();
        check("jc_untaken", {instr_out, pc_jmp}, 2'b10);
        tick();
        check("jc_untaken_wrap", step_out, 0);
        opcode = 4'h8;
        flags = 4'b0010;
        tick(); tick();
        check("jz_taken", pc_jmp, 1);
        tick();
        opcode = 4'hF;
        tick(); tick();
        check("hlt_t2", {halt, step_out}, {1'b1, 4'd2});
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halted", {halt, step_out}, {1'b1, 4'd2});
            check("halted_ctl", ctl(), 0);
        end
        pr_mode = 1'b1;
        tick();
        check("prog_from_halt", {halt, step_out}, 5'd0);
        check("prog_ctl", ctl(), 0);
        pr_mode = 1'b0;
        tick();
        check("restart_t0", {pc_out, mar_in, step_out}, {2'b11, 4'd0});
        opcode = 4'h2;
        tick();
        pr_mode = 1'b1;
        tick();
        check("add_t2", {instr_out, mar_in, step_out}, {2'b11, 4'd2});
        tick();
        check("add_t3", reg_b_in, 1);
        tick();
        check("add_t4", {alu_out, alu_sub, reg_a_in, reg_flags_in}, {3'b101, 4'hF});
        tick();
        check("add_to_prog", {halt, step_out}, 5'd0);
        check("add_prog_ctl", ctl(), 0);
        tick();
        check("prog_hold", ctl(), 0);
        pr_mode = 1'b0;
        tick();
        check("prog_exit_t0", {pc_out, step_out}, {1'b1, 4'd0});
        opcode = 4'h4;
        tick(); tick(); tick();
        check("sta_t3", {reg_a_out, ram_in, step_out}, {2'b11, 4'd3});
        #1 rst = 1'b0;
        #1;
        check("sta_rst", {reg_a_out, ram_in, step_out}, 6'd0);
        check("sta_rst_ctl", ctl(), 0);
        tick();
        rst = 1'b1;
        opcode = 4'hE;
        #1;
        check("rerun_t0", {pc_out, step_out}, {1'b1, 4'd0});
        tick();
        check("rerun_arm", step_out, 0);
        tick(); tick();
        check("out_t2", {reg_a_out, reg_out, instr_out}, 3'b110);
        tick();
        check("out_wrap", step_out, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sap1_sequencer.md
# sap1_sequencer

Microcode control sequencer for the SAP-1 CPU. It runs a 5-step T-state counter and decodes the instruction register opcode, plus the flag register, into the control word that drives the shared 8-bit bus and its attached units (A/B registers, ALU, IR, MAR, RAM, PC, output register, flags). It also owns the run / halted / program-mode state. While the block is halted or in program mode, it keeps every bus driver released so the RAM loader can use the bus.

## Interface
- FLAG_C_BIT, 0, index of carry in `flags`
- FLAG_Z_BIT, 1, index of zero in `flags`

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- opcode  in  4  IR upper nibble, stable from end of T1
- flags  in  4  flag register contents
- pr_mode  in  1  program-mode request from the loader
- halt  out  1  CPU halted
- reg_a_in, reg_a_out, reg_b_in, reg_b_out  out  1 each  A/B register load/drive
- alu_out, alu_sub  out  1 each  ALU drive / subtract select
- instr_in, instr_out  out  1 each  IR load / drive operand nibble
- mar_in, ram_in, ram_out  out  1 each  MAR load, RAM write, RAM drive
- reg_out  out  1  output register load
- pc_inc, pc_out, pc_jmp  out  1 each  PC increment / drive / load
- reg_flags_in  out  4  per-bit flag load enables
- step_out  out  4  current T-state (0–4), debug

## Operation
- States:
  - RUN: step counter advances.
  - HALTED: step frozen; halt=1; all other controls 0.
  - PROGRAM: step=0; all controls 0; halt=0.
- Control outputs decode combinationally from state, step, opcode and flags. Every output is 0 except in RUN, and except halt in HALTED.
- Fetch, common to all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, instr_in, pc_inc.
- Execute:
  - 0 NOP: T2 none; last step T2.
  - 1 LDA: T2 instr_out, mar_in. T3 ram_out, reg_a_in. Last step T3.
  - 2 ADD: T2 instr_out, mar_in. T3 ram_out, reg_b_in. T4 alu_out, reg_a_in, reg_flags_in=4'b1111. Last step T4.
  - 3 SUB: as ADD, with alu_sub=1 in T4.
  - 4 STA: T2 instr_out, mar_in. T3 reg_a_out, ram_in. Last step T3.
  - 5 LDI: T2 instr_out, reg_a_in. Last step T2.
  - 6 JMP: T2 instr_out, pc_jmp. Last step T2.
  - 7 JC: T2 instr_out, plus pc_jmp only if flags[FLAG_C_BIT]. Last step T2.
  - 8 JZ: T2 instr_out, plus pc_jmp only if flags[FLAG_Z_BIT]. Last step T2.
  - E OUT: T2 reg_a_out, reg_out. Last step T2.
  - F HLT: T2 halt=1. Last step T2; next state HALTED.
  - 9–D: treated as NOP.
- Step advance: on the last step, step goes to 0. Otherwise step increments. Step never exceeds 4.
- Untaken JC/JZ still ends at T2. No stall cycle.
- pr_mode:
  - In RUN it is sampled only on the clock edge that leaves the last step. If high there, the next state is PROGRAM instead of T0. The current instruction always completes.
  - In HALTED, pr_mode=1 moves to PROGRAM on the next edge.
  - In PROGRAM, pr_mode=0 moves to RUN at T0 on the next edge.
- HLT combined with pr_mode=1 at that edge: PROGRAM wins.
- Leaving HALTED requires pr_mode or reset.

## Timing
- Reset (rst=0): state RUN, step 0, all outputs 0 including halt, step_out=0. Outputs are forced to 0 for the whole time rst is low.
- First edge after rst rises: no step change, so that edge is spent in T0. T0 controls become visible immediately after release.
- Cycle counts per instruction: NOP, LDI, JMP, JC, JZ, OUT and HLT take 3 cycles; LDA and STA take 4; ADD and SUB take 5.
- Controls are valid for the entire step cycle. The datapath latches on the rising edge that ends the step.
- opcode and flags are sampled combinationally during T2–T4. ADD/SUB flags are written at the end of T4, so a JC/JZ that follows sees them.
- Reset mid-instruction: immediate return to the reset values. No partial control pulse is held.
- halt asserts combinationally in T2 of HLT and stays 1 from the next edge until the state exits HALTED.

## Test plan
- Release reset with opcode=1 (LDA): step_out sequence is 0,1,2,3,0. In T3, ram_out=1 and reg_a_in=1. reg_flags_in stays 0 throughout.
- opcode=3 (SUB): T4 shows alu_out, alu_sub, reg_a_in and reg_flags_in=4'b1111. Step wraps 4 to 0. Total 5 cycles.
- opcode=7 with flags=4'b0001: pc_jmp=1 in T2. Repeat with flags=4'b0000: pc_jmp=0 and step still wraps to 0 after T2. opcode=8 with flags=4'b0010: pc_jmp=1.
- opcode=F: halt=1 in T2. After that, halt stays 1, step_out stays 2 and all other controls are 0 for 10 cycles. Raising pr_mode gives halt=0 and step_out=0 on the next edge. Dropping pr_mode restarts at T0.
- Raise pr_mode during T1 of ADD: T2–T4 still execute, then the state enters PROGRAM with all controls 0.
- Pull rst low during T3 of STA: ram_in and reg_a_out drop immediately and step_out=0. After release, the sequencer restarts at T0.
